// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - pipelined bitwise logic unit with valid/ready handshake
//
// Purpose: computes AND/OR/XOR/NAND of two WIDTH-bit operands and carries the
// result through STAGES register stages. The whole pipe shifts together and
// stalls globally under output backpressure.
//
// Optional feature macro: ZERO_FLAG_EN (adds registered out_zero flag).
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand beat valid
//   in_ready   out  unit accepts a beat this cycle
//   op         in   00=AND 01=OR 10=XOR 11=NAND
//   a, b       in   WIDTH-bit operands
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result
//   result     out  op(a,b) of the presented beat
//   out_zero   out  (ZERO_FLAG_EN only) result == 0, aligned with result
module logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
`ifdef ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  generate
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
      $error("logic_unit_pipe: STAGES must be in 1..4");
    end
  endgenerate

  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  dat [STAGES];
  logic [WIDTH-1:0]  op_res;
  logic              advance;
  logic              accept;

  // Pipe only holds when the last stage has a beat the consumer refuses;
  // bubbles are not squeezed out, so the whole pipe moves or nothing does.
  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  always_comb begin
    op_res = '0;
    case (op)
      2'b00: op_res = a & b;
      2'b01: op_res = a | b;
      2'b10: op_res = a ^ b;
      2'b11: op_res = ~(a & b);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) dat[i] <= '0;
    end else if (advance) begin
      vld[0] <= accept;
      dat[0] <= op_res;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign out_valid = vld[STAGES-1];
  assign result    = dat[STAGES-1];

`ifdef ZERO_FLAG_EN
  logic [STAGES-1:0] zf;

  always_ff @(posedge clk) begin
    if (rst) begin
      zf <= '0;
    end else if (advance) begin
      zf[0] <= (op_res == '0);
      for (int i = 1; i < STAGES; i++) zf[i] <= zf[i-1];
    end
  end

  assign out_zero = zf[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb/tb_logic_unit_pipe.sv - self-checking bench for logic_unit_pipe
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] result;
`ifdef ZERO_FLAG_EN
  logic       out_zero;
`endif

  logic_unit_pipe #(.WIDTH(8), .STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int accepts = 0;
  bit mon_en = 1'b0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_res;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    case (o)
      2'd0: return x & y;
      2'd1: return x | y;
      2'd2: return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
    in_valid = v;
    op = o;
    a = x;
    b = y;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted beat is queued; every emitted beat must match
  // the oldest queued one. A reset discards everything in flight.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        chk("in_ready_rule", {31'b0, in_ready}, {31'b0, !(out_valid && !out_ready)});
        if (prev_stall) begin
          chk("stall_valid", {31'b0, out_valid}, 32'd1);
          chk("stall_hold", {24'b0, result}, {24'b0, prev_res});
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", 32'd1, 32'd0);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("sb_result", {24'b0, result}, {24'b0, e});
`ifdef ZERO_FLAG_EN
            chk("sb_zero", {31'b0, out_zero}, {31'b0, (e == 8'h00)});
`endif
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(model(op, a, b));
          accepts++;
        end
        prev_stall = out_valid && !out_ready;
        prev_res   = result;
      end
    end
  end

  initial begin
    int start;
    int cyc;

    tbl[0] = '{2'b00, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{2'b01, 8'hF0, 8'h3C, 8'hFC};
    tbl[2] = '{2'b10, 8'hF0, 8'h3C, 8'hCC};
    tbl[3] = '{2'b11, 8'hF0, 8'h3C, 8'hCF};
    tbl[4] = '{2'b00, 8'hFF, 8'h00, 8'h00};
    tbl[5] = '{2'b11, 8'h00, 8'h00, 8'hFF};
    tbl[6] = '{2'b10, 8'hFF, 8'hFF, 8'h00};
    tbl[7] = '{2'b01, 8'hA5, 8'h5A, 8'hFF};

    // T1: reset
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t1_result", {24'b0, result}, 32'd0);
    chk("t1_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ZERO_FLAG_EN
    chk("t1_out_zero", {31'b0, out_zero}, 32'd0);
`endif
    mon_en = 1'b1;
    next_cycle();

    // T2: back-to-back table vectors, 2-cycle latency
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, tbl[i].op, tbl[i].a, tbl[i].b);
      else       drive(1'b0, 2'b00, 8'h00, 8'h00);
      @(negedge clk);
      if (i >= 2) begin
        chk("t2_valid", {31'b0, out_valid}, 32'd1);
        chk("t2_result", {24'b0, result}, {24'b0, tbl[i-2].exp});
      end else begin
        chk("t2_not_yet_valid", {31'b0, out_valid}, 32'd0);
      end
      next_cycle();
    end

    // T3: fill, stall 3 cycles, release
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 8'h11, 8'h22);
    @(negedge clk);
    chk("t3_ready_a", {31'b0, in_ready}, 32'd1);
    next_cycle();
    drive(1'b1, 2'b10, 8'hF0, 8'h0F);
    @(negedge clk);
    chk("t3_ready_b", {31'b0, in_ready}, 32'd1);
    next_cycle();
    drive(1'b1, 2'b00, 8'hC3, 8'h81);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_stall_ready", {31'b0, in_ready}, 32'd0);
      chk("t3_stall_valid", {31'b0, out_valid}, 32'd1);
      chk("t3_stall_result", {24'b0, result}, 32'h33);
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_rel_result0", {24'b0, result}, 32'h33);
    chk("t3_rel_ready", {31'b0, in_ready}, 32'd1);
    next_cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t3_rel_result1", {24'b0, result}, 32'hFF);
    next_cycle();
    @(negedge clk);
    chk("t3_rel_result2", {24'b0, result}, 32'h81);
    chk("t3_rel_valid2", {31'b0, out_valid}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t3_drained", {31'b0, out_valid}, 32'd0);
    next_cycle();

    // T4: random traffic, 1000 accepted beats, checked by the scoreboard
    start = accepts;
    cyc = 0;
    while ((accepts - start) < 1000 && cyc < 20000) begin
      drive(1'($urandom % 2), 2'($urandom % 4), 8'($urandom), 8'($urandom));
      out_ready = 1'($urandom % 2);
      next_cycle();
      cyc++;
    end
    chk("t4_beats_accepted", 32'(accepts - start >= 1000), 32'd1);
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      next_cycle();
      cyc++;
    end
    chk("t4_all_emitted", 32'(exp_q.size()), 32'd0);
    repeat (2) next_cycle();

    // T5: reset with two beats in flight
    drive(1'b1, 2'b01, 8'h01, 8'h02);
    next_cycle();
    drive(1'b1, 2'b01, 8'h04, 8'h08);
    next_cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    out_ready = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_flushed", {31'b0, out_valid}, 32'd0);
      next_cycle();
    end
    drive(1'b1, 2'b10, 8'h3C, 8'h0F);
    next_cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t5_new_not_yet", {31'b0, out_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("t5_new_valid", {31'b0, out_valid}, 32'd1);
    chk("t5_new_result", {24'b0, result}, 32'h33);
    next_cycle();

`ifdef ZERO_FLAG_EN
    // T6: zero flag aligned with result
    drive(1'b1, 2'b00, 8'h55, 8'hAA);
    next_cycle();
    drive(1'b1, 2'b01, 8'h55, 8'hAA);
    next_cycle();
    drive(1'b0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("t6_result_and", {24'b0, result}, 32'h00);
    chk("t6_zero_and", {31'b0, out_zero}, 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t6_result_or", {24'b0, result}, 32'hFF);
    chk("t6_zero_or", {31'b0, out_zero}, 32'd0);
    next_cycle();
`endif

    repeat (2) next_cycle();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
